subway_path_checker: RTL
========================

Name: subway_path_checker

Overview:
- Scoreboard stage directly downstream of the subway path generator. It consumes the same 4-lane obstacle map and the generator's action stream (out_valid/out).
- It replays the runner cycle by cycle and reports pass/fail, the first failing step and an error code.
- It is used as an in-system checker and as a reusable bench monitor.

Parameters:
- COLS, 64, number of map columns; the action stream length is COLS-1.
- LANES, 4, number of lanes (fixed at 4; 2-bit lane index).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- map_valid  in  1  map column valid; COLS consecutive cycles
- map_init  in  2  start lane; sampled only on the first map_valid cycle
- map_in0..map_in3  in  2 each  cell code of lanes 0..3 for the current column
- act_valid  in  1  action valid (the generator's out_valid)
- act  in  2  action (the generator's out)
- res_valid  out  1  one-cycle result strobe
- res_pass  out  1  1 = legal path
- res_step  out  6  index of the first failing action (0..COLS-2); 0 when passing
- res_code  out  3  first error code; 0 when passing

Behaviour:
- Decided: one clock; reset is synchronous and active-high, ports clk and rst.
- Encodings:
  - Cell: 0 road, 1 low obstacle, 2 high obstacle, 3 train.
  - Action: 0 forward, 1 right (lane+1), 2 left (lane-1), 3 jump.
- Error codes:
  - 1: off edge.
  - 2: train hit.
  - 3: low obstacle not jumped.
  - 4: jump into high obstacle.
  - 5: stream short (act_valid dropped early).
  - 6: stream long (more than COLS-1 actions).
  - 7: start lane on a non-road cell.
- On rst: every output is 0, FSM is IDLE, the lane register is 0, and the map storage contents are don't-care.
- FSM:
  - IDLE -> LOAD on map_valid. The first column is written and map_init is latched into lane.
  - LOAD: writes one column per map_valid cycle using a column counter. map_valid low before COLS columns returns to IDLE with no result.
  - After column COLS-1 -> WAIT_ACT.
  - WAIT_ACT: if cell(lane,0) != 0, latch error 7 at step 0. Move -> CHECK on the first act_valid, which is processed that same cycle.
  - CHECK: step counter s = 0.., one action per act_valid cycle.
    - Candidate lane: lane+1 for right, lane-1 for left, unchanged otherwise.
    - Candidate off the range 0..3 -> error 1.
    - Otherwise check c = cell(candidate, s+1): c = 3 -> error 2; c = 1 and act != 3 -> error 3; c = 2 and act = 3 -> error 4.
    - lane is updated to the candidate only when the action is legal.
  - act_valid low in CHECK with s < COLS-1 -> error 5 at step s, then go to REPORT.
  - After action s = COLS-2 -> REPORT. If act_valid is still high the next cycle, error 6 at step COLS-1 is flagged (saturating at 63).
  - REPORT: res_valid high exactly one cycle, then IDLE.
- Only the first error is latched. Later actions are still consumed, but stepping continues from the last legal lane.
- Latency:
  - Complete stream: res_valid is asserted 2 cycles after the last act_valid (one cycle spent detecting stream end).
  - Short stream: res_valid is asserted 1 cycle after act_valid falls.
- Simultaneous events:
  - map_valid during CHECK or REPORT is ignored.
  - act_valid during LOAD is ignored and counted nowhere.
  - rst mid-stream aborts with no res_valid.
- Arithmetic: lane math is 3-bit signed-safe; compare before truncating to 2 bits. The step counter is 6 bits.

Optional Feature:
- Macro SUBWAY_CHK_TRACE_EN.
- When defined: adds outputs trace_valid (1) and trace_lane (2). trace_lane carries the runner lane after each CHECK action, aligned with that action plus 1 cycle. trace_valid is 0 at reset and outside CHECK.
- When undefined: the ports and their logic are absent. Result behaviour is identical either way.

Decomposition:
- Package subway_pkg: cell codes, action codes, error codes, COLS default, FSM state typedef.
- One sub-module, subway_map_ram: LANES x COLS x 2-bit register file.
  - Write port: one full column per cycle.
  - Read port: asynchronous, addressed by (lane, column).
  - Must be reusable by the generator stage.

Test Plan:
- All-road map, init 2, 63 forward actions -> res_pass 1, res_code 0, res_step 0, res_valid 2 cycles after the last action.
- Lane 2 column 5 = 1, init 2, act 3 at step 4, forward elsewhere -> pass. The same stream with forward at step 4 -> res_code 3, res_step 4.
- Init 0, act 2 at step 0 -> res_code 1, res_step 0. Init 3, act 1 at step 10 -> res_code 1, res_step 10.
- Lane 1 column 20 = 3, init 1, all forward -> res_code 2, res_step 19. Injecting a second error later still reports step 19.
- act_valid for only 40 cycles -> res_code 5, res_step 40. A 64-cycle stream on a legal path -> res_code 6, res_step 63.
- rst pulsed at action 30, then a full legal map and stream -> no res_valid for the aborted run, pass for the second run.

Source files
------------

// File: rtl/subway_pkg.sv
// ============================================================================
//  Module      : subway_pkg
//  Description : Shared encodings for the subway path generator/checker stages.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package subway_pkg;

   localparam int c_cols_default = 64;

   typedef enum logic [1:0] {
      CELL_ROAD  = 2'd0,
      CELL_LOW   = 2'd1,
      CELL_HIGH  = 2'd2,
      CELL_TRAIN = 2'd3
   } cell_e;

   typedef enum logic [1:0] {
      ACT_FWD   = 2'd0,
      ACT_RIGHT = 2'd1,
      ACT_LEFT  = 2'd2,
      ACT_JUMP  = 2'd3
   } act_e;

   localparam logic [2:0] c_err_none     = 3'd0;
   localparam logic [2:0] c_err_off_edge = 3'd1;
   localparam logic [2:0] c_err_train    = 3'd2;
   localparam logic [2:0] c_err_low      = 3'd3;
   localparam logic [2:0] c_err_high     = 3'd4;
   localparam logic [2:0] c_err_short    = 3'd5;
   localparam logic [2:0] c_err_long     = 3'd6;
   localparam logic [2:0] c_err_start    = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOAD     = 3'd1,
      S_WAIT_ACT = 3'd2,
      S_CHECK    = 3'd3,
      S_TAIL     = 3'd4,
      S_REPORT   = 3'd5
   } state_e;

endpackage

`default_nettype wire

// File: rtl/subway_map_ram.sv
// ============================================================================
//  Module      : subway_map_ram
//  Description : LANES x COLS x 2-bit map store; one full column written per
//                cycle, asynchronous (lane, column) read.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module subway_map_ram #(
   parameter int COLS  = 64,
   parameter int LANES = 4
) (
   input  logic                       clk,
   input  logic                       i_wr_en,
   input  logic [$clog2(COLS)-1:0]    i_wr_col,
   input  logic [LANES-1:0][1:0]      i_wr_cells,
   input  logic [$clog2(LANES)-1:0]   i_rd_lane,
   input  logic [$clog2(COLS)-1:0]    i_rd_col,
   output logic [1:0]                 o_rd_cell
);

   logic [LANES-1:0][1:0] w_lane_cells;

   generate
      for (genvar g = 0; g < LANES; g++) begin : g_lane
         logic [1:0] r_col_mem [COLS];

         always_ff @(posedge clk) begin
            if (i_wr_en) begin
               r_col_mem[i_wr_col] <= i_wr_cells[g];
            end
         end

         assign w_lane_cells[g] = r_col_mem[i_rd_col];
      end
   endgenerate

   assign o_rd_cell = w_lane_cells[i_rd_lane];

endmodule

`default_nettype wire

// File: rtl/subway_path_checker.sv
// ============================================================================
//  Module      : subway_path_checker
//  Description : Replays the runner over a stored 4-lane map and reports
//                pass/fail, first failing step and error code.
//                Optional lane trace outputs: define SUBWAY_CHK_TRACE_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module subway_path_checker
   import subway_pkg::*;
#(
   parameter int COLS  = c_cols_default,
   parameter int LANES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       map_valid,
   input  logic [1:0] map_init,
   input  logic [1:0] map_in0,
   input  logic [1:0] map_in1,
   input  logic [1:0] map_in2,
   input  logic [1:0] map_in3,
   input  logic       act_valid,
   input  logic [1:0] act,
   output logic       res_valid,
   output logic       res_pass,
   output logic [5:0] res_step,
   output logic [2:0] res_code
`ifdef SUBWAY_CHK_TRACE_EN
   ,
   output logic       trace_valid,
   output logic [1:0] trace_lane
`endif
);

   localparam int              CW          = $clog2(COLS);
   localparam logic [5:0]      c_last_step = 6'(COLS - 2);
   localparam logic [5:0]      c_long_step = (COLS - 1 > 63) ? 6'd63 : 6'(COLS - 1);
   localparam logic [CW-1:0]   c_last_col  = CW'(COLS - 1);

   state_e           r_state, w_state_nxt;
   logic [1:0]       r_lane;
   logic [CW-1:0]    r_col;
   logic [5:0]       r_step;
   logic [2:0]       r_err_code;
   logic [5:0]       r_err_step;
   logic             r_start_bad;

   logic [2:0]       w_cand;
   logic [1:0]       w_cell;
   logic [1:0]       w_init_cell;
   logic [2:0]       w_err;
   logic [2:0]       w_flag_code;
   logic [5:0]       w_flag_step;
   logic             w_fire;
   logic             w_wr_en;
   logic [CW-1:0]    w_wr_col;
   logic [CW-1:0]    w_rd_col;
   logic [LANES-1:0][1:0] w_wr_cells;

   assign w_wr_cells = {map_in3, map_in2, map_in1, map_in0};
   assign w_wr_en    = map_valid && (r_state == S_IDLE || r_state == S_LOAD);
   assign w_wr_col   = (r_state == S_IDLE) ? '0 : r_col;
   assign w_rd_col   = r_step[CW-1:0] + CW'(1);
   assign w_fire     = act_valid && (r_state == S_WAIT_ACT || r_state == S_CHECK);

   subway_map_ram #(
      .COLS  (COLS),
      .LANES (LANES)
   ) u_map_ram (
      .clk        (clk),
      .i_wr_en    (w_wr_en),
      .i_wr_col   (w_wr_col),
      .i_wr_cells (w_wr_cells),
      .i_rd_lane  (w_cand[1:0]),
      .i_rd_col   (w_rd_col),
      .o_rd_cell  (w_cell)
   );

   // Start-lane cell is taken straight off the input bus, so the single RAM
   // read port stays free for the step-0 action in the same cycle.
   always_comb begin
      w_init_cell = map_in0;
      case (map_init)
         2'd1:    w_init_cell = map_in1;
         2'd2:    w_init_cell = map_in2;
         2'd3:    w_init_cell = map_in3;
         default: w_init_cell = map_in0;
      endcase
   end

   // Candidate lane kept at 3 bits so both -1 and 4 read as out of range.
   always_comb begin
      w_cand = {1'b0, r_lane};
      if (act == ACT_RIGHT) begin
         w_cand = w_cand + 3'd1;
      end else if (act == ACT_LEFT) begin
         w_cand = w_cand - 3'd1;
      end
      w_err = c_err_none;
      if (w_cand > 3'd3) begin
         w_err = c_err_off_edge;
      end else if (w_cell == CELL_TRAIN) begin
         w_err = c_err_train;
      end else if (w_cell == CELL_LOW && act != ACT_JUMP) begin
         w_err = c_err_low;
      end else if (w_cell == CELL_HIGH && act == ACT_JUMP) begin
         w_err = c_err_high;
      end
   end

   always_comb begin
      w_flag_code = c_err_none;
      w_flag_step = r_step;
      case (r_state)
         S_WAIT_ACT: begin
            if (r_start_bad) begin
               w_flag_code = c_err_start;
               w_flag_step = '0;
            end else if (act_valid) begin
               w_flag_code = w_err;
            end
         end
         S_CHECK: begin
            w_flag_code = act_valid ? w_err : c_err_short;
         end
         S_TAIL: begin
            if (act_valid) begin
               w_flag_code = c_err_long;
               w_flag_step = c_long_step;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:     if (map_valid) w_state_nxt = S_LOAD;
         S_LOAD: begin
            if (!map_valid)              w_state_nxt = S_IDLE;
            else if (r_col == c_last_col) w_state_nxt = S_WAIT_ACT;
         end
         S_WAIT_ACT: if (act_valid) w_state_nxt = (r_step == c_last_step) ? S_TAIL : S_CHECK;
         S_CHECK: begin
            if (!act_valid)                w_state_nxt = S_REPORT;
            else if (r_step == c_last_step) w_state_nxt = S_TAIL;
         end
         S_TAIL:     w_state_nxt = S_REPORT;
         S_REPORT:   w_state_nxt = S_IDLE;
         default:    w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_lane      <= '0;
         r_col       <= '0;
         r_step      <= '0;
         r_err_code  <= c_err_none;
         r_err_step  <= '0;
         r_start_bad <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_IDLE && map_valid) begin
            r_lane      <= map_init;
            r_col       <= CW'(1);
            r_step      <= '0;
            r_err_code  <= c_err_none;
            r_err_step  <= '0;
            r_start_bad <= (w_init_cell != CELL_ROAD);
         end else begin
            if (r_state == S_LOAD && map_valid) begin
               r_col <= r_col + CW'(1);
            end
            if (r_err_code == c_err_none && w_flag_code != c_err_none) begin
               r_err_code <= w_flag_code;
               r_err_step <= w_flag_step;
            end
            // Illegal actions leave the runner on its last legal lane.
            if (w_fire) begin
               r_step <= r_step + 6'd1;
               if (w_err == c_err_none) begin
                  r_lane <= w_cand[1:0];
               end
            end
         end
      end
   end

   assign res_valid = (r_state == S_REPORT);
   assign res_pass  = (r_state == S_REPORT) && (r_err_code == c_err_none);
   assign res_step  = (r_state == S_REPORT) ? r_err_step : 6'd0;
   assign res_code  = (r_state == S_REPORT) ? r_err_code : c_err_none;

`ifdef SUBWAY_CHK_TRACE_EN
   logic       r_trace_valid;
   logic [1:0] r_trace_lane;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_trace_valid <= 1'b0;
         r_trace_lane  <= '0;
      end else begin
         r_trace_valid <= w_fire;
         if (w_fire) begin
            r_trace_lane <= (w_err == c_err_none) ? w_cand[1:0] : r_lane;
         end
      end
   end

   assign trace_valid = r_trace_valid;
   assign trace_lane  = r_trace_lane;
`endif

endmodule

`default_nettype wire
